// File: rtl/mod_const_mul_seq_if.sv
// Operand/result valid-ready channels for mod_const_mul_seq.
// out_err exists only when MODCALC_ERR_EN is defined.
interface mod_const_mul_seq_if #(
    parameter int W = 6,
    parameter int M = 47
);
    localparam int MW = $clog2(M);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_z;
`ifdef MODCALC_ERR_EN
    logic          out_err;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_z, out_err
    );
    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_z, out_err
    );
`else
    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_z
    );
    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_z
    );
`endif
endinterface

// File: rtl/mod_const_mul_seq.sv
// Sequential z = (x*K) mod M, MSB-first shift-add, one operand bit per cycle.
// Optional MODCALC_ERR_EN adds out_err flagging non-canonical operands (x >= M).
module mod_const_mul_seq #(
    parameter int W = 6,
    parameter int M = 47,
    parameter int K = 77
) (
    input  logic               clk,
    input  logic               rst_n,
    mod_const_mul_seq_if.slave bus
);
    // state | meaning
    // IDLE  | ready for an operand
    // RUN   | one Horner step per cycle, MSB first
    // DONE  | result held until downstream accepts it
    localparam int MW = $clog2(M);
    localparam int KR = K % M;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [MW:0]   M_V     = (MW + 1)'(M);
    localparam logic [MW:0]   KR_V    = (MW + 1)'(KR);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  x_sr;
    logic [CW-1:0] cnt;
    logic [MW:0]   acc;
    logic [MW-1:0] z_reg;
    logic [MW:0]   t_dbl, t_red, t_add, t_next;

    // acc < M keeps every intermediate below 2M, so MW+1 bits never overflow.
    always_comb begin
        t_dbl  = acc << 1;
        t_red  = (t_dbl >= M_V) ? t_dbl - M_V : t_dbl;
        t_add  = t_red + KR_V;
        t_next = t_red;
        if (x_sr[W-1]) begin
            t_next = (t_add >= M_V) ? t_add - M_V : t_add;
        end
    end

`ifdef MODCALC_ERR_EN
    localparam int XW = (W > MW + 1) ? W : MW + 1;
    logic err_flag;
    logic err_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
            err_out  <= 1'b0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                err_flag <= (XW'(bus.in_x) >= XW'(M));
            end
            if (state == RUN && cnt == '0) begin
                err_out <= err_flag;
            end else if (state == DONE && bus.out_ready) begin
                err_out <= 1'b0;
            end
        end
    end

    assign bus.out_err = err_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x_sr  <= '0;
            cnt   <= '0;
            acc   <= '0;
            z_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_sr  <= bus.in_x;
                        acc   <= '0;
                        cnt   <= CNT_TOP;
                        state <= RUN;
                    end
                end
                RUN: begin
                    x_sr <= x_sr << 1;
                    acc  <= t_next;
                    if (cnt == '0) begin
                        z_reg <= t_next[MW-1:0];
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_z     = z_reg;
endmodule

// File: tb/tb_mod_const_mul_seq.sv
// Self-checking bench for mod_const_mul_seq: default instance plus two sweep instances.
// Reference results come from plain (x*K) mod M arithmetic.
module tb_mod_const_mul_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mod_const_mul_seq_if #(.W(6), .M(47))  bus0 ();
    mod_const_mul_seq_if #(.W(8), .M(251)) bus8 ();
    mod_const_mul_seq_if #(.W(4), .M(3))   bus4 ();

    mod_const_mul_seq #(.W(6), .M(47), .K(77)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    mod_const_mul_seq #(.W(8), .M(251), .K(300)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    mod_const_mul_seq #(.W(4), .M(3), .K(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    function automatic int ref_mod(input longint x, input longint k, input longint m);
        return int'((x * k) % m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op0(input int x, input int hold, output int z, output int lat, output int err);
        int guard = 0;
        bus0.in_x = 6'(x);
        bus0.in_valid = 1'b1;
        bus0.out_ready = 1'b0;
        while (!bus0.in_ready && guard < 50) begin tick(); guard++; end
        tick();
        bus0.in_valid = 1'b0;
        lat = 0;
        while (!bus0.out_valid && lat < 50) begin tick(); lat++; end
        repeat (hold) tick();
        z = int'(bus0.out_z);
`ifdef MODCALC_ERR_EN
        err = int'(bus0.out_err);
`else
        err = 0;
`endif
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
    endtask

    task automatic op8(input int x, output int z, output int lat);
        int guard = 0;
        bus8.in_x = 8'(x);
        bus8.in_valid = 1'b1;
        while (!bus8.in_ready && guard < 50) begin tick(); guard++; end
        tick();
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 50) begin tick(); lat++; end
        z = int'(bus8.out_z);
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
    endtask

    task automatic op4(input int x, output int z, output int lat);
        int guard = 0;
        bus4.in_x = 4'(x);
        bus4.in_valid = 1'b1;
        while (!bus4.in_ready && guard < 50) begin tick(); guard++; end
        tick();
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 50) begin tick(); lat++; end
        z = int'(bus4.out_z);
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.out_z !== 6'd0) begin
            $display("FAIL reset_outputs in_ready=%b out_valid=%b out_z=%0d required 1/0/0",
                     bus0.in_ready, bus0.out_valid, bus0.out_z);
        end else n_pass++;
`ifdef MODCALC_ERR_EN
        n_total++;
        if (bus0.out_err !== 1'b0) $display("FAIL reset_err got=%b required 0", bus0.out_err);
        else n_pass++;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int xs[3] = '{1, 2, 0};
        int z, lat, err;
        foreach (xs[i]) begin
            op0(xs[i], 0, z, lat, err);
            n_total++;
            if (z !== ref_mod(xs[i], 77, 47))
                $display("FAIL basic_z x=%0d got=%0d required=%0d", xs[i], z, ref_mod(xs[i], 77, 47));
            else n_pass++;
            n_total++;
            if (lat !== 6) $display("FAIL basic_latency x=%0d got=%0d required=6", xs[i], lat);
            else n_pass++;
        end
    endtask

    task automatic test_noncanonical();
        int xs[2] = '{63, 46};
        int z, lat, err;
        foreach (xs[i]) begin
            op0(xs[i], 1, z, lat, err);
            n_total++;
            if (z !== ref_mod(xs[i], 77, 47) || lat !== 6)
                $display("FAIL noncanon_z x=%0d got=%0d lat=%0d required=%0d lat=6",
                         xs[i], z, lat, ref_mod(xs[i], 77, 47));
            else n_pass++;
`ifdef MODCALC_ERR_EN
            n_total++;
            if (err !== int'(xs[i] >= 47))
                $display("FAIL noncanon_err x=%0d got=%0d required=%0d", xs[i], err, int'(xs[i] >= 47));
            else n_pass++;
`endif
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        int stray = 0;
        int exp_z = ref_mod(46, 77, 47);
        bus0.in_x = 6'd46;
        bus0.in_valid = 1'b1;
        bus0.out_ready = 1'b0;
        tick();
        bus0.in_valid = 1'b0;
        while (!bus0.out_valid && guard < 50) begin tick(); guard++; end
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (bus0.out_z !== 6'(exp_z) || bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1)
                $display("FAIL bp_hold cycle=%0d out_z=%0d in_ready=%b out_valid=%b required %0d/0/1",
                         i, bus0.out_z, bus0.in_ready, bus0.out_valid, exp_z);
            else n_pass++;
            if (i == 2) begin
                bus0.in_x = 6'd5;
                bus0.in_valid = 1'b1;
            end else begin
                bus0.in_valid = 1'b0;
            end
            tick();
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        n_total++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1)
            $display("FAIL bp_release out_valid=%b in_ready=%b required 0/1", bus0.out_valid, bus0.in_ready);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            if (bus0.out_valid === 1'b1) stray++;
            tick();
        end
        n_total++;
        if (stray !== 0) $display("FAIL bp_ignored_pulse result_cycles=%0d required=0", stray);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int xs[3] = '{1, 2, 63};
        int acc_cyc[$];
        int res[$];
        int idx = 0;
        int cyc = 0;
        logic a, r;
        logic [5:0] zs;
        bus0.in_x = 6'(xs[0]);
        bus0.in_valid = 1'b1;
        bus0.out_ready = 1'b1;
        while (res.size() < 3 && cyc < 80) begin
            a  = bus0.in_valid & bus0.in_ready;
            r  = bus0.out_valid & bus0.out_ready;
            zs = bus0.out_z;
            tick();
            cyc++;
            if (a) begin
                acc_cyc.push_back(cyc);
                idx++;
                if (idx < 3) bus0.in_x = 6'(xs[idx]);
                else bus0.in_valid = 1'b0;
            end
            if (r) res.push_back(int'(zs));
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (res.size() <= i) $display("FAIL b2b_result idx=%0d got=none required=%0d", i, ref_mod(xs[i], 77, 47));
            else if (res[i] !== ref_mod(xs[i], 77, 47))
                $display("FAIL b2b_result idx=%0d got=%0d required=%0d", i, res[i], ref_mod(xs[i], 77, 47));
            else n_pass++;
        end
        for (int i = 1; i < 3; i++) begin
            n_total++;
            if (acc_cyc.size() <= i) $display("FAIL b2b_spacing idx=%0d got=none required=8", i);
            else if (acc_cyc[i] - acc_cyc[i-1] !== 8)
                $display("FAIL b2b_spacing idx=%0d got=%0d required=8", i, acc_cyc[i] - acc_cyc[i-1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int z, lat, err;
        bus0.in_x = 6'd63;
        bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus0.out_valid !== 1'b0 || bus0.out_z !== 6'd0 || bus0.in_ready !== 1'b1)
            $display("FAIL abort_outputs out_valid=%b out_z=%0d in_ready=%b required 0/0/1",
                     bus0.out_valid, bus0.out_z, bus0.in_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        op0(1, 0, z, lat, err);
        n_total++;
        if (z !== ref_mod(1, 77, 47) || lat !== 6)
            $display("FAIL abort_recover got=%0d lat=%0d required=%0d lat=6", z, lat, ref_mod(1, 77, 47));
        else n_pass++;
    endtask

    task automatic test_random();
        int x, hold, z, lat, err;
        for (int i = 0; i < 16; i++) begin
            x = int'($urandom_range(0, 63));
            hold = int'($urandom_range(0, 3));
            op0(x, hold, z, lat, err);
            n_total++;
            if (z !== ref_mod(x, 77, 47) || lat !== 6)
                $display("FAIL random x=%0d got=%0d lat=%0d required=%0d lat=6", x, z, lat, ref_mod(x, 77, 47));
            else n_pass++;
        end
    endtask

    task automatic test_sweep_w8();
        int z, lat;
        for (int x = 0; x < 256; x++) begin
            op8(x, z, lat);
            n_total++;
            if (z !== ref_mod(x, 300, 251) || lat !== 8)
                $display("FAIL sweep_w8 x=%0d got=%0d lat=%0d required=%0d lat=8", x, z, lat, ref_mod(x, 300, 251));
            else n_pass++;
        end
    endtask

    task automatic test_sweep_w4();
        int z, lat;
        for (int x = 0; x < 16; x++) begin
            op4(x, z, lat);
            n_total++;
            if (z !== ref_mod(x, 2, 3) || lat !== 4)
                $display("FAIL sweep_w4 x=%0d got=%0d lat=%0d required=%0d lat=4", x, z, lat, ref_mod(x, 2, 3));
            else n_pass++;
        end
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.in_x = '0; bus0.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_x = '0; bus8.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_x = '0; bus4.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_noncanonical();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_sweep_w8();
        test_sweep_w4();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
